// File: rtl/layer_step_sequencer.sv
// Layer step sequencer: walks weight load, bias load and conv phases
// per layer, with a per-phase watchdog and abort.
module layer_step_sequencer #(
  parameter int NUM_LAYERS   = 29,
  parameter int TIMEOUT      = 65535,
  parameter int LAST_NO_BIAS = 1,
  parameter logic [NUM_LAYERS-1:0] ONEXONE_MAP = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       wload_done,
  input  logic       bload_done,
  input  logic       conv_done,
  output logic [6:0] step_out,
  output logic [4:0] layer_idx,
  output logic       load_weights,
  output logic       load_bias,
  output logic       conv_go,
  output logic       onexone,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
  localparam logic [4:0] LAST = 5'(NUM_LAYERS - 1);
  localparam logic [31:0] MAP32 = 32'(ONEXONE_MAP);
  localparam bit SKIP_B = (LAST_NO_BIAS != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    CONV   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_n;
  logic [4:0]    layer_q;
  logic [4:0]    layer_n;
  logic [WW-1:0] wdog_q;
  logic [WW-1:0] wdog_n;
  logic          go_q;
  logic          done_q;
  logic          fin_n;
  logic          phase_done;
  logic          active;
  logic          expired;
  logic [6:0]    base;

  assign active  = (state_q == LOAD_W) ||
                   (state_q == LOAD_B) ||
                   (state_q == CONV);
  assign expired = (wdog_q == WD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      layer_q <= '0;
      wdog_q  <= '0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      layer_q <= layer_n;
      wdog_q  <= wdog_n;
      go_q    <= (state_n == CONV) &&
                 (state_q != CONV);
      done_q  <= fin_n;
    end
  end

  always_comb begin
    phase_done = 1'b0;
    unique case (state_q)
      LOAD_W:  phase_done = wload_done;
      LOAD_B:  phase_done = bload_done;
      CONV:    phase_done = conv_done;
      default: phase_done = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state_q;
    layer_n = layer_q;
    fin_n   = 1'b0;
    unique case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_n = LOAD_W;
          layer_n = '0;
        end
      end
      LOAD_W: begin
        if (phase_done) begin
          if (SKIP_B && layer_q == LAST)
            state_n = CONV;
          else
            state_n = LOAD_B;
        end else if (expired) begin
          state_n = ERR;
          layer_n = '0;
        end
      end
      LOAD_B: begin
        if (phase_done) begin
          state_n = CONV;
        end else if (expired) begin
          state_n = ERR;
          layer_n = '0;
        end
      end
      CONV: begin
        if (phase_done) begin
          if (layer_q == LAST) begin
            state_n = IDLE;
            layer_n = '0;
            fin_n   = 1'b1;
          end else begin
            state_n = LOAD_W;
            layer_n = layer_q + 5'd1;
          end
        end else if (expired) begin
          state_n = ERR;
          layer_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        layer_n = '0;
      end
    endcase
    // abort beats start, done and timeout alike
    if (abort) begin
      state_n = IDLE;
      layer_n = '0;
      fin_n   = 1'b0;
    end
  end

  always_comb begin
    wdog_n = '0;
    if (state_n == state_q && active)
      wdog_n = wdog_q + WW'(1);
  end

  assign base = {2'b00, layer_q} +
                {1'b0, layer_q, 1'b0};

  always_comb begin
    step_out     = 7'd0;
    load_weights = 1'b0;
    load_bias    = 1'b0;
    busy         = 1'b0;
    err          = 1'b0;
    unique case (1'b1)
      (state_q == LOAD_W): begin
        step_out     = base + 7'd1;
        load_weights = 1'b1;
        busy         = 1'b1;
      end
      (state_q == LOAD_B): begin
        step_out  = base + 7'd2;
        load_bias = 1'b1;
        busy      = 1'b1;
      end
      (state_q == CONV): begin
        step_out = base + 7'd3;
        busy     = 1'b1;
      end
      (state_q == ERR): begin
        err = 1'b1;
      end
      default: begin
        step_out = 7'd0;
      end
    endcase
  end

  assign layer_idx = layer_q;
  assign conv_go   = go_q;
  assign done      = done_q;
  assign onexone   = active & MAP32[layer_q];

endmodule

// File: doc/layer_step_sequencer.md
LAYER_STEP_SEQUENCER -- requirements
Module: layer_step_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 29, the number of layers sequenced.
REQ-002 SHALL have parameter TIMEOUT, default 65535, the maximum cycles allowed in any active phase before error.
REQ-003 SHALL have parameter LAST_NO_BIAS, default 1; when 1, the last layer skips its bias phase.
REQ-004 SHALL have parameter ONEXONE_MAP, NUM_LAYERS bits, default 0; bit L=1 marks layer L as a 1x1 conv.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, a one-cycle request to begin the network from layer 0.
REQ-008 SHALL have port abort, input, 1, a synchronous request to cancel the current run.
REQ-009 SHALL have port wload_done, input, 1, meaning the weight loader has finished the current layer.
REQ-010 SHALL have port bload_done, input, 1, meaning the bias loader has finished the current layer.
REQ-011 SHALL have port conv_done, input, 1, meaning the conv engine has finished the current layer.
REQ-012 SHALL have port step_out, output, 7, the global step number driving address decode.
REQ-013 SHALL have port layer_idx, output, 5, the current layer, 0-based.
REQ-014 SHALL have port load_weights, output, 1, high while in the weight phase.
REQ-015 SHALL have port load_bias, output, 1, high while in the bias phase.
REQ-016 SHALL have port conv_go, output, 1, a one-cycle pulse on entry to the conv phase.
REQ-017 SHALL have port onexone, output, 1, equal to ONEXONE_MAP[layer_idx] while busy, else 0.
REQ-018 SHALL have port busy, output, 1, high in LOAD_W, LOAD_B and CONV.
REQ-019 SHALL have ports done and err, outputs, 1 each: done is a one-cycle completion pulse; err is held high in ERR.

Function
REQ-020 SHALL implement exactly the states IDLE, LOAD_W, LOAD_B, CONV and ERR.
REQ-021 SHALL encode step_out as 3L+1 in LOAD_W, 3L+2 in LOAD_B, 3L+3 in CONV, and 0 in IDLE/ERR, with L = layer_idx.
REQ-022 In IDLE or ERR, start=1 SHALL move to LOAD_W with layer_idx=0 on the next edge and clear err.
REQ-023 In LOAD_W, wload_done=1 SHALL move to LOAD_B, or to CONV when L=NUM_LAYERS-1 and LAST_NO_BIAS=1.
REQ-024 In LOAD_B, bload_done=1 SHALL move to CONV.
REQ-025 Every entry into CONV SHALL assert conv_go for exactly one cycle, the first cycle in CONV.
REQ-026 In CONV, conv_done=1 with L<NUM_LAYERS-1 SHALL increment layer_idx and move to LOAD_W.
REQ-027 In CONV, conv_done=1 with L=NUM_LAYERS-1 SHALL move to IDLE, pulse done for one cycle and reset layer_idx to 0.
REQ-028 Done inputs SHALL be ignored outside their own phase; start SHALL be ignored while busy.
REQ-029 Transition latency SHALL be one cycle: a qualifying input sampled at edge N changes state/outputs after edge N.
REQ-030 The watchdog counter SHALL reset to 0 on every phase entry and increment each cycle in LOAD_W/LOAD_B/CONV.
REQ-031 When the watchdog reaches TIMEOUT-1 and the phase's done input is low, the block SHALL enter ERR; a done arriving on that same cycle SHALL win.
REQ-032 abort=1 SHALL force IDLE from any state on the next edge with layer_idx=0 and no done pulse; abort SHALL override a simultaneous start or done.
REQ-033 step_out arithmetic SHALL be unsigned; NUM_LAYERS is limited to ≤32 and 3*NUM_LAYERS ≤127, with no wrap-around.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE with step_out=0, layer_idx=0, watchdog=0, and load_weights, load_bias, conv_go, onexone, busy, done and err all at 0.
REQ-035 Reset asserted mid-run SHALL discard all progress; after release the block SHALL wait in IDLE for start.

Verification
REQ-036 NUM_LAYERS=2, LAST_NO_BIAS=1: start, then each done 3 cycles after phase entry -> step_out sequence 1,2,3,4,6, one conv_go per CONV entry, one done pulse, then IDLE.
REQ-037 Timeout: TIMEOUT=8, wload_done never asserted -> ERR 8 cycles after LOAD_W entry with err=1 and step_out=0; a subsequent start -> step_out=1 and err=0.
REQ-038 Abort in LOAD_B of layer 1 together with bload_done -> IDLE, layer_idx=0, no done pulse, no conv_go.
REQ-039 ONEXONE_MAP=2'b10 -> onexone=0 for steps 1-3 and onexone=1 for steps 4-6; start pulses while busy have no effect.
REQ-040 rst_n pulled low during CONV of layer 1 -> all outputs 0 immediately, without waiting for a clock edge.
REQ-041 Stray bload_done and conv_done while in LOAD_W -> remains in LOAD_W with step_out unchanged.
